// File: rtl/conv3d_fold.sv
// rtl/conv3d_fold.sv - folded conv3d output stage: PE_NUM MAC lanes over CHANNELS_OUT kernels,
// with bias, optional ReLU, rounding shift and saturation, and valid/ready on both sides.
module conv3d_fold #(
  parameter int DIN_WIDTH    = 8,
  parameter int KERN_WIDTH   = 16,
  parameter int BIAS_WIDTH   = 32,
  parameter int DOUT_WIDTH   = 8,
  parameter int WIN_SIZE     = 3,
  parameter int CHANNELS_IN  = 4,
  parameter int CHANNELS_OUT = 128,
  parameter int PE_NUM       = 32,
  localparam int PROD_WIDTH  = DIN_WIDTH + KERN_WIDTH + $clog2(CHANNELS_IN * WIN_SIZE * WIN_SIZE),
  localparam int ACC_WIDTH   = ((PROD_WIDTH > BIAS_WIDTH) ? PROD_WIDTH : BIAS_WIDTH) + 1,
  localparam int SHIFT_W     = $clog2(ACC_WIDTH)
) (
  input  logic clk,
  input  logic reset,
  input  logic [CHANNELS_OUT-1:0][CHANNELS_IN-1:0][WIN_SIZE-1:0][WIN_SIZE-1:0][KERN_WIDTH-1:0] kernel,
  input  logic [CHANNELS_OUT-1:0][BIAS_WIDTH-1:0] bias,
  input  logic [SHIFT_W-1:0] shift,
  input  logic relu_en,
  input  logic fin_start,
  input  logic win_vld,
  output logic win_rdy,
  input  logic [CHANNELS_IN-1:0][WIN_SIZE-1:0][WIN_SIZE-1:0][DIN_WIDTH-1:0] window,
  output logic fout_start,
  output logic dout_vld,
  input  logic dout_rdy,
  output logic [CHANNELS_OUT-1:0][DOUT_WIDTH-1:0] dout
);

  localparam int FOLD   = CHANNELS_OUT / PE_NUM;
  localparam int FOLD_W = (FOLD > 1) ? $clog2(FOLD) : 1;
  localparam int CO_W   = (CHANNELS_OUT > 1) ? $clog2(CHANNELS_OUT) : 1;
  // Wide enough that the rounding constant for any shift code cannot overflow
  localparam int RW     = ACC_WIDTH + (1 << SHIFT_W) + 1;
  localparam logic signed [RW-1:0] DMAX = RW'(2 ** (DOUT_WIDTH - 1) - 1);
  localparam logic signed [RW-1:0] DMIN = RW'(-(2 ** (DOUT_WIDTH - 1)));

  if (CHANNELS_OUT % PE_NUM != 0) begin : g_bad_cfg
    $error("conv3d_fold: CHANNELS_OUT must be a multiple of PE_NUM");
  end

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  state_t state, state_nxt;
  logic [FOLD_W-1:0] fold;
  logic [CHANNELS_IN-1:0][WIN_SIZE-1:0][WIN_SIZE-1:0][DIN_WIDTH-1:0] window_q;
  logic fin_q;
  logic relu_q;
  logic [SHIFT_W-1:0] shift_q;
  logic [DOUT_WIDTH-1:0] lane_out [PE_NUM];

  function automatic logic signed [ACC_WIDTH-1:0] sx_din(input logic [DIN_WIDTH-1:0] v);
    return {{(ACC_WIDTH - DIN_WIDTH){v[DIN_WIDTH-1]}}, v};
  endfunction

  function automatic logic signed [ACC_WIDTH-1:0] sx_kern(input logic [KERN_WIDTH-1:0] v);
    return {{(ACC_WIDTH - KERN_WIDTH){v[KERN_WIDTH-1]}}, v};
  endfunction

  function automatic logic signed [ACC_WIDTH-1:0] sx_bias(input logic [BIAS_WIDTH-1:0] v);
    return {{(ACC_WIDTH - BIAS_WIDTH){v[BIAS_WIDTH-1]}}, v};
  endfunction

  function automatic logic [DOUT_WIDTH-1:0] requant(input logic signed [ACC_WIDTH-1:0] acc,
                                                    input logic [SHIFT_W-1:0] sh,
                                                    input logic relu);
    logic signed [RW-1:0] a;
    logic signed [RW-1:0] rnd;
    a = {{(RW - ACC_WIDTH){acc[ACC_WIDTH-1]}}, acc};
    if (relu && a[RW-1]) a = '0;
    if (sh != '0) begin
      rnd    = '0;
      rnd[0] = 1'b1;
      rnd    = rnd <<< (sh - SHIFT_W'(1));
      a      = (a + rnd) >>> sh;
    end
    if (a > DMAX) a = DMAX;
    else if (a < DMIN) a = DMIN;
    return a[DOUT_WIDTH-1:0];
  endfunction

  for (genvar p = 0; p < PE_NUM; p++) begin : g_lane
    logic [CO_W-1:0] ch;
    logic signed [ACC_WIDTH-1:0] acc;
    always_comb begin
      ch  = CO_W'(int'(fold) * PE_NUM + p);
      acc = sx_bias(bias[ch]);
      for (int i = 0; i < CHANNELS_IN; i++)
        for (int y = 0; y < WIN_SIZE; y++)
          for (int x = 0; x < WIN_SIZE; x++)
            acc = acc + sx_din(window_q[i][y][x]) * sx_kern(kernel[ch][i][y][x]);
    end
    assign lane_out[p] = requant(acc, shift_q, relu_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    win_rdy    = 1'b0;
    dout_vld   = 1'b0;
    fout_start = 1'b0;
    case (state)
      IDLE: begin
        win_rdy = ~reset;
        if (win_vld) state_nxt = CALC;
      end
      CALC: if (fold == FOLD_W'(FOLD - 1)) state_nxt = OUT;
      OUT: begin
        dout_vld   = 1'b1;
        fout_start = fin_q;
        if (dout_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fold     <= '0;
      window_q <= '0;
      fin_q    <= 1'b0;
      relu_q   <= 1'b0;
      shift_q  <= '0;
      dout     <= '0;
    end else begin
      case (state)
        IDLE: if (win_vld) begin
          window_q <= window;
          fin_q    <= fin_start;
          relu_q   <= relu_en;
          shift_q  <= shift;
          fold     <= '0;
        end
        CALC: begin
          fold <= fold + FOLD_W'(1);
          for (int c = 0; c < CHANNELS_OUT; c++)
            if (fold == FOLD_W'(c / PE_NUM)) dout[c] <= lane_out[c % PE_NUM];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv3d_fold.sv
// tb/tb_conv3d_fold.sv - directed self-checking bench for conv3d_fold
module tb_conv3d_fold;
  logic clk = 1'b0;
  logic reset;
  logic [127:0][3:0][2:0][2:0][15:0] kernel;
  logic [127:0][31:0] bias;
  logic [5:0] shift;
  logic relu_en, fin_start, win_vld, win_rdy, fout_start, dout_vld, dout_rdy;
  logic [3:0][2:0][2:0][7:0] window;
  logic [127:0][7:0] dout;

  int errors = 0;
  int checks = 0;
  int lat;

  logic [7:0] t5_win  [3] = '{8'd1, 8'd3, 8'hFF};
  logic [7:0] t5_exp0 [3] = '{8'd36, 8'd108, 8'hDC};
  logic [7:0] t5_exp1 [3] = '{8'd82, 8'd127, 8'hC2};
  logic       t5_fst  [3] = '{1'b1, 1'b0, 1'b0};

  conv3d_fold dut (
    .clk(clk), .reset(reset), .kernel(kernel), .bias(bias), .shift(shift),
    .relu_en(relu_en), .fin_start(fin_start), .win_vld(win_vld), .win_rdy(win_rdy),
    .window(window), .fout_start(fout_start), .dout_vld(dout_vld), .dout_rdy(dout_rdy),
    .dout(dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_win(input logic [7:0] v);
    for (int i = 0; i < 4; i++)
      for (int y = 0; y < 3; y++)
        for (int x = 0; x < 3; x++)
          window[i][y][x] = v;
  endtask

  task automatic set_kern(input int ch, input logic [15:0] v);
    for (int i = 0; i < 4; i++)
      for (int y = 0; y < 3; y++)
        for (int x = 0; x < 3; x++)
          kernel[ch][i][y][x] = v;
  endtask

  task automatic send(input logic fs);
    int n;
    n = 0;
    fin_start = fs;
    win_vld = 1'b1;
    while (!win_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("win_rdy_wait", win_rdy, 1);
    @(posedge clk);
    @(negedge clk);
    win_vld = 1'b0;
    fin_start = 1'b0;
  endtask

  task automatic wait_vld(output int l);
    l = 99;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (dout_vld) begin
        l = k;
        break;
      end
    end
  endtask

  task automatic handshake();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; kernel = '0; bias = '0; shift = '0; relu_en = 1'b0;
    fin_start = 1'b0; win_vld = 1'b0; dout_rdy = 1'b1; window = '0;
    @(negedge clk);
    chk("rst_win_rdy", win_rdy, 0);
    chk("rst_dout_vld", dout_vld, 0);
    chk("rst_fout_start", fout_start, 0);
    chk("rst_dout_zero", dout == '0, 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_win_rdy", win_rdy, 1);

    // T1: single dot product and latency
    set_win(8'd1);
    set_kern(0, 16'd1);
    send(1'b0);
    chk("t1_busy_win_rdy", win_rdy, 0);
    wait_vld(lat);
    chk("t1_latency", lat, 4);
    chk("t1_dout0", dout[0], 36);
    chk("t1_dout1", dout[1], 0);
    chk("t1_dout127", dout[127], 0);
    chk("t1_fout_start", fout_start, 0);
    handshake();
    chk("t1_vld_drop", dout_vld, 0);
    chk("t1_win_rdy_back", win_rdy, 1);

    // T2: saturation and ReLU
    set_win(8'd127);
    for (int c = 0; c < 128; c++) set_kern(c, 16'd127);
    send(1'b0);
    wait_vld(lat);
    chk("t2_sat_hi_d0", dout[0], 127);
    chk("t2_sat_hi_d127", dout[127], 127);
    handshake();
    for (int c = 0; c < 128; c++) set_kern(c, 16'hFF81);
    send(1'b0);
    wait_vld(lat);
    chk("t2_sat_lo_d64", dout[64], 8'h80);
    handshake();
    relu_en = 1'b1;
    send(1'b0);
    wait_vld(lat);
    chk("t2_relu_d100", dout[100], 0);
    handshake();
    relu_en = 1'b0;

    // T3: rounding shift and bias
    kernel = '0;
    set_win(8'd1);
    bias[3] = 32'd6;
    bias[4] = -32'sd6;
    bias[9] = 32'd2;
    bias[10] = -32'sd2;
    shift = 6'd2;
    send(1'b0);
    wait_vld(lat);
    chk("t3_round_pos6", dout[3], 2);
    chk("t3_round_neg6", dout[4], 8'hFF);
    chk("t3_round_half_pos", dout[9], 1);
    chk("t3_round_half_neg", dout[10], 0);
    handshake();
    shift = 6'd0;
    set_kern(5, 16'd1);
    bias[5] = -32'sd36;
    bias[6] = -32'sd200;
    send(1'b0);
    wait_vld(lat);
    chk("t3_bias_cancel", dout[5], 0);
    chk("t3_bias_sat_lo", dout[6], 8'h80);
    handshake();

    // T4: downstream backpressure
    kernel = '0;
    bias = '0;
    set_kern(0, 16'd1);
    set_win(8'd1);
    dout_rdy = 1'b0;
    send(1'b0);
    wait_vld(lat);
    chk("t4_latency", lat, 4);
    set_win(8'd2);
    win_vld = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk("t4_hold_vld", dout_vld, 1);
      chk("t4_hold_dout0", dout[0], 36);
      chk("t4_hold_win_rdy", win_rdy, 0);
      @(negedge clk);
    end
    dout_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t4_after_hs_win_rdy", win_rdy, 1);
    chk("t4_after_hs_vld", dout_vld, 0);
    @(posedge clk);
    @(negedge clk);
    win_vld = 1'b0;
    chk("t4_second_accepted", win_rdy, 0);
    wait_vld(lat);
    chk("t4_second_latency", lat, 4);
    chk("t4_second_dout0", dout[0], 72);
    handshake();

    // T5: frame start marker over three windows
    set_kern(1, 16'd2);
    bias[1] = 32'd10;
    for (int k = 0; k < 3; k++) begin
      set_win(t5_win[k]);
      send(k == 0);
      wait_vld(lat);
      chk("t5_dout0", dout[0], t5_exp0[k]);
      chk("t5_dout1", dout[1], t5_exp1[k]);
      chk("t5_fout_start", fout_start, t5_fst[k]);
      handshake();
    end

    // T6: reset in the middle of CALC
    set_win(8'd1);
    send(1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t6_dout_cleared", dout == '0, 1);
    chk("t6_dout_vld", dout_vld, 0);
    chk("t6_win_rdy", win_rdy, 0);
    chk("t6_fout_start", fout_start, 0);
    @(negedge clk);
    reset = 1'b0;
    set_win(8'd2);
    send(1'b1);
    wait_vld(lat);
    chk("t6_latency", lat, 4);
    chk("t6_dout0", dout[0], 72);
    chk("t6_dout1", dout[1], 127);
    chk("t6_fout_start_new", fout_start, 1);
    handshake();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
